// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered RV32 decode stage between fetch and execute. Each accepted
//   instruction is split into fields. The stage builds the sign-extended
//   immediate, assigns a format and a class, and flags illegal encodings.
//   A 2-entry elastic buffer (output register + skid) keeps full throughput
//   under back-pressure. in_ready comes straight from state, so it never
//   depends combinationally on out_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop buffered and same-cycle input instructions
//   in_valid/in_ready   upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc .. out_csr_addr  decoded fields of the instruction at the head
//   illegal_count       saturating count of delivered illegal instructions
module instr_decode_stage #(
    parameter int XLEN         = 32,
    parameter int PC_W         = 32,
    parameter int ENABLE_M     = 1,
    parameter int ENABLE_ZICSR = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [3:0]       out_class,
    output logic             out_illegal,
    output logic [11:0]      out_csr_addr,
    output logic [CNT_W-1:0] illegal_count
);

    // Format codes
    localparam logic [2:0] T_R    = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_NONE = 3'd7;

    // Class codes
    localparam logic [3:0] C_ALU_R  = 4'd0;
    localparam logic [3:0] C_ALU_I  = 4'd1;
    localparam logic [3:0] C_LOAD   = 4'd2;
    localparam logic [3:0] C_STORE  = 4'd3;
    localparam logic [3:0] C_BRANCH = 4'd4;
    localparam logic [3:0] C_JAL    = 4'd5;
    localparam logic [3:0] C_JALR   = 4'd6;
    localparam logic [3:0] C_LUI    = 4'd7;
    localparam logic [3:0] C_AUIPC  = 4'd8;
    localparam logic [3:0] C_FENCE  = 4'd9;
    localparam logic [3:0] C_SYSTEM = 4'd10;
    localparam logic [3:0] C_MULDIV = 4'd11;
    localparam logic [3:0] C_ILL    = 4'd15;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [3:0]      cls;
        logic            illegal;
        logic [11:0]     csr_addr;
    } dec_t;

    state_t state_q, state_d;
    dec_t   out_q, skid_q, dec;
    logic   load_out, load_skid, out_from_skid;
    logic   in_xfer, out_xfer;
    logic [CNT_W-1:0] cnt_q;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]         op;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [2:0]         fmt;
    logic [3:0]         cls;
    logic               legal;
    logic signed [31:0] imm32;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        fmt   = T_NONE;
        cls   = C_ILL;
        legal = 1'b1;
        case (op)
            7'b0110011: begin
                fmt = T_R;
                if (f7 == 7'b0000000)
                    cls = C_ALU_R;
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    cls = C_ALU_R;
                else if (f7 == 7'b0000001 && ENABLE_M != 0)
                    cls = C_MULDIV;
                else
                    legal = 1'b0;
            end
            7'b0010011: begin
                fmt = T_I;
                cls = C_ALU_I;
                // Shift-immediates reuse funct7 as a sub-opcode
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    legal = 1'b0;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    legal = 1'b0;
            end
            7'b0000011: begin
                fmt = T_I;
                cls = C_LOAD;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    legal = 1'b0;
            end
            7'b0100011: begin
                fmt = T_S;
                cls = C_STORE;
                if (f3 >= 3'b011)
                    legal = 1'b0;
            end
            7'b1100011: begin
                fmt = T_B;
                cls = C_BRANCH;
                if (f3 == 3'b010 || f3 == 3'b011)
                    legal = 1'b0;
            end
            7'b1100111: begin
                fmt = T_I;
                cls = C_JALR;
                if (f3 != 3'b000)
                    legal = 1'b0;
            end
            7'b1101111: begin
                fmt = T_J;
                cls = C_JAL;
            end
            7'b0110111: begin
                fmt = T_U;
                cls = C_LUI;
            end
            7'b0010111: begin
                fmt = T_U;
                cls = C_AUIPC;
            end
            7'b0001111: begin
                fmt = T_I;
                cls = C_FENCE;
                if (f3 != 3'b000 && f3 != 3'b001)
                    legal = 1'b0;
            end
            7'b1110011: begin
                fmt = T_I;
                cls = C_SYSTEM;
                if (f3 == 3'b100)
                    legal = 1'b0;
                else if (f3 == 3'b000) begin
                    // Only the exact privileged encodings are accepted
                    if (in_instr != 32'h0000_0073 && in_instr != 32'h0010_0073 &&
                        in_instr != 32'h3020_0073 && in_instr != 32'h1050_0073)
                        legal = 1'b0;
                end else if (ENABLE_ZICSR == 0)
                    legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11)
            legal = 1'b0;
    end

    always_comb begin
        case (fmt)
            T_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            T_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B:     imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            T_U:     imm32 = {in_instr[31:12], 12'b0};
            T_J:     imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = op;
        if (!legal) begin
            dec.typ     = T_NONE;
            dec.cls     = C_ILL;
            dec.illegal = 1'b1;
        end else begin
            dec.typ = fmt;
            dec.cls = cls;
            dec.imm = XLEN'(imm32);
            if (fmt == T_R || fmt == T_I || fmt == T_U || fmt == T_J)
                dec.rd = in_instr[11:7];
            if (fmt == T_R || fmt == T_I || fmt == T_S || fmt == T_B)
                dec.rs1 = in_instr[19:15];
            if (fmt == T_R || fmt == T_S || fmt == T_B)
                dec.rs2 = in_instr[24:20];
            if (fmt != T_U && fmt != T_J)
                dec.funct3 = f3;
            if (fmt == T_R) begin
                dec.funct7 = f7;
                dec.imm    = '0;
            end
            if (cls == C_SYSTEM)
                dec.csr_addr = in_instr[31:20];
        end
    end

    // ------------------------------------------------------------------
    // Elastic buffer control: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_d  = S_ONE;
                        load_out = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer)
                        load_out = 1'b1;
                    else if (in_xfer) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer)
                        state_d = S_EMPTY;
                end
                S_TWO: begin
                    if (out_xfer) begin
                        state_d       = S_ONE;
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != S_TWO);
        out_valid = (state_q != S_EMPTY);
    end

    // ------------------------------------------------------------------
    // Payload registers and illegal counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)
                out_q <= out_from_skid ? skid_q : dec;
            if (load_skid)
                skid_q <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (out_xfer && out_q.illegal && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign out_pc        = out_q.pc;
    assign out_opcode    = out_q.opcode;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_funct3    = out_q.funct3;
    assign out_funct7    = out_q.funct7;
    assign out_imm       = out_q.imm;
    assign out_type      = out_q.typ;
    assign out_class     = out_q.cls;
    assign out_illegal   = out_q.illegal;
    assign out_csr_addr  = out_q.csr_addr;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
`timescale 1ns/1ps
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    // Full-featured instance
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_type;
    logic [3:0]  out_class;
    logic [11:0] out_csr_addr;
    logic [15:0] illegal_count;

    // Instance without M and Zicsr, fed the same stream
    logic        l_in_ready, l_out_valid, l_out_illegal;
    logic [31:0] l_out_pc, l_out_imm;
    logic [6:0]  l_out_opcode, l_out_funct7;
    logic [4:0]  l_out_rd, l_out_rs1, l_out_rs2;
    logic [2:0]  l_out_funct3, l_out_type;
    logic [3:0]  l_out_class;
    logic [11:0] l_out_csr_addr;
    logic [15:0] l_illegal_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_M(1), .ENABLE_ZICSR(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_type(out_type), .out_class(out_class), .out_illegal(out_illegal),
        .out_csr_addr(out_csr_addr), .illegal_count(illegal_count)
    );

    instr_decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_M(0), .ENABLE_ZICSR(0), .CNT_W(16)) dut_lite (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_pc(l_out_pc),
        .out_opcode(l_out_opcode), .out_rd(l_out_rd), .out_rs1(l_out_rs1), .out_rs2(l_out_rs2),
        .out_funct3(l_out_funct3), .out_funct7(l_out_funct7), .out_imm(l_out_imm),
        .out_type(l_out_type), .out_class(l_out_class), .out_illegal(l_out_illegal),
        .out_csr_addr(l_out_csr_addr), .illegal_count(l_illegal_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", illegal_count, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_class", out_class, 0);

        // addi x1,x0,-1
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h100;
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_class", out_class, 1);
        chk("addi_type", out_type, 1);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_pc", out_pc, 32'h100);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        in_instr = 32'h0020_A423; in_pc = 32'h104;
        tick();
        chk("sw_class", out_class, 3);
        chk("sw_type", out_type, 2);
        chk("sw_rs1", out_rs1, 1);
        chk("sw_rs2", out_rs2, 2);
        chk("sw_rd", out_rd, 0);
        chk("sw_imm", out_imm, 8);
        chk("sw_pc", out_pc, 32'h104);
        in_instr = 32'hFE00_0EE3; in_pc = 32'h108;
        tick();
        chk("beq_class", out_class, 4);
        chk("beq_type", out_type, 3);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_pc", out_pc, 32'h108);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // Back-pressure: three addis against a stalled consumer
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0113; in_pc = 32'h200;
        tick();
        chk("bp1_in_ready", in_ready, 1);
        chk("bp1_rd", out_rd, 2);
        in_instr = 32'h0020_0193; in_pc = 32'h204;
        tick();
        chk("bp2_in_ready", in_ready, 0);
        chk("bp2_rd", out_rd, 2);
        in_instr = 32'h0030_0213; in_pc = 32'h208;
        tick();
        chk("bp3_in_ready", in_ready, 0);
        chk("bp3_rd", out_rd, 2);
        out_ready = 1'b1;
        tick();
        chk("bp4_valid", out_valid, 1);
        chk("bp4_rd", out_rd, 3);
        chk("bp4_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp5_valid", out_valid, 1);
        chk("bp5_rd", out_rd, 4);
        chk("bp5_imm", out_imm, 3);
        chk("bp5_pc", out_pc, 32'h208);
        tick();
        chk("bp6_valid", out_valid, 0);

        // mul x3,x1,x2
        in_valid = 1'b1; in_instr = 32'h0220_81B3; in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        chk("mul_class", out_class, 11);
        chk("mul_funct7", out_funct7, 7'b0000001);
        chk("mul_illegal", out_illegal, 0);
        chk("mul_lite_illegal", l_out_illegal, 1);
        chk("mul_lite_class", l_out_class, 15);
        chk("mul_lite_type", l_out_type, 7);
        tick();
        chk("mul_count", illegal_count, 0);
        chk("mul_lite_count", l_illegal_count, 1);

        // csrrs x5,cycle,x0
        in_valid = 1'b1; in_instr = 32'hC000_22F3; in_pc = 32'h304;
        tick();
        in_valid = 1'b0;
        chk("csr_class", out_class, 10);
        chk("csr_addr", out_csr_addr, 12'hC00);
        chk("csr_rd", out_rd, 5);
        chk("csr_lite_class", l_out_class, 15);
        tick();
        chk("csr_lite_count", l_illegal_count, 2);

        // addi x0,x0,0 with bits[1:0]=00
        in_valid = 1'b1; in_instr = 32'h0000_0010; in_pc = 32'h308;
        tick();
        in_valid = 1'b0;
        chk("ill_flag", out_illegal, 1);
        chk("ill_class", out_class, 15);
        chk("ill_type", out_type, 7);
        chk("ill_imm", out_imm, 0);
        tick();
        chk("ill_count", illegal_count, 1);
        chk("ill_lite_count", l_illegal_count, 3);

        // ecall, jal x1,-4, lui x10,0x12345 back to back
        in_valid = 1'b1; in_instr = 32'h0000_0073; in_pc = 32'h400;
        tick();
        chk("ecall_class", out_class, 10);
        chk("ecall_lite_class", l_out_class, 10);
        in_instr = 32'hFFDF_F0EF; in_pc = 32'h404;
        tick();
        chk("jal_class", out_class, 5);
        chk("jal_type", out_type, 5);
        chk("jal_imm", out_imm, 32'hFFFF_FFFC);
        chk("jal_rd", out_rd, 1);
        in_instr = 32'h1234_5537; in_pc = 32'h408;
        tick();
        in_valid = 1'b0;
        chk("lui_class", out_class, 7);
        chk("lui_type", out_type, 4);
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", out_rd, 10);
        chk("lui_funct3", out_funct3, 0);
        tick();
        chk("legal_count", illegal_count, 1);

        // Fill to TWO with illegal words, then flush with a live input
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'h500;
        tick();
        in_pc = 32'h504;
        tick();
        chk("two_in_ready", in_ready, 0);
        flush = 1'b1; in_instr = 32'h0010_0113; in_pc = 32'h508;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        tick();
        chk("flush_valid2", out_valid, 0);
        tick();
        chk("flush_valid3", out_valid, 0);
        chk("flush_count", illegal_count, 1);

        // Saturation: 65533 more illegal deliveries reach 0xFFFE, two more saturate
        in_valid = 1'b1; in_instr = 32'h0000_0000;
        for (int i = 0; i < 65533; i++) begin
            in_pc = i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("sat_pre", illegal_count, 16'hFFFE);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        tick();
        chk("sat_count", illegal_count, 16'hFFFF);
        chk("sat_lite_count", l_illegal_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
